// File: rtl/psk_frame_modulator_if.sv
// Byte-input handshake and modulated-sample output bundle for psk_frame_modulator.
// The byte source and sample sink sit on master; the modulator sits on slave.
interface psk_frame_modulator_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [7:0]                   in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic                         mode;
    logic signed [DATA_WIDTH-1:0] tx_sample;
    logic                         tx_sample_valid;
    logic                         tx_active;
    logic                         packet_done;

    modport master (
        output in_data, in_valid, mode,
        input  in_ready, tx_sample, tx_sample_valid, tx_active, packet_done
    );

    modport slave (
        input  in_data, in_valid, mode,
        output in_ready, tx_sample, tx_sample_valid, tx_active, packet_done
    );
endinterface

// File: rtl/psk_frame_modulator.sv
// BPSK/QPSK packet modulator: bytes fill ping-pong banks, full banks are serialised
// MSB-first into phase-shifted sine samples from an elaboration-time table.
module psk_frame_modulator #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned SINE_RESOLUTION = 64,
    parameter int unsigned WAVELENGTH      = 4,
    parameter int unsigned SYMBOL_PERIODS  = 1,
    parameter int unsigned PACKET_BYTES    = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    psk_frame_modulator_if.slave   bus
);
    localparam int unsigned N         = SINE_RESOLUTION;
    localparam int unsigned KW        = $clog2(N);
    localparam int unsigned TotalBits = PACKET_BYTES * 8;
    localparam int unsigned BitPosW   = $clog2(TotalBits);
    localparam int unsigned HoldW     = (WAVELENGTH > 1) ? $clog2(WAVELENGTH) : 1;
    localparam int unsigned PerW      = (SYMBOL_PERIODS > 1) ? $clog2(SYMBOL_PERIODS) : 1;
    localparam int unsigned PtrW      = $clog2(PACKET_BYTES);

    localparam logic [HoldW-1:0]   HoldLast   = HoldW'(WAVELENGTH - 1);
    localparam logic [PerW-1:0]    PerLast    = PerW'(SYMBOL_PERIODS - 1);
    localparam logic [KW-1:0]      KLast      = KW'(N - 1);
    localparam logic [PtrW-1:0]    PtrLast    = PtrW'(PACKET_BYTES - 1);
    localparam logic [BitPosW-1:0] LastBpsk   = BitPosW'(TotalBits - 1);
    localparam logic [BitPosW-1:0] LastQpsk   = BitPosW'(TotalBits - 2);
    localparam logic [KW-1:0]      OffQuarter = KW'(N / 4);
    localparam logic [KW-1:0]      OffHalf    = KW'(N / 2);
    localparam logic [KW-1:0]      Off3Q      = KW'((3 * N) / 4);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StSend = 2'd2;

    // Rounded half away from zero so the table is symmetric about zero.
    function automatic logic signed [DATA_WIDTH-1:0] sin_entry(input int unsigned k);
        real amp;
        real v;
        int  r;
        amp = real'((2 ** (DATA_WIDTH - 1)) - 1);
        v   = amp * $sin(2.0 * 3.14159265358979 * real'(k) / real'(N));
        r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return r[DATA_WIDTH-1:0];
    endfunction

    logic signed [DATA_WIDTH-1:0] sin_tab [N];

    for (genvar g = 0; g < N; g++) begin : g_tab
        assign sin_tab[g] = sin_entry(g);
    end

    logic [TotalBits-1:0] bank_q [2];
    logic [1:0]           full_q, full_d;
    logic                 fill_bank_q, fill_bank_d;
    logic [PtrW-1:0]      fill_ptr_q, fill_ptr_d;
    logic [1:0]           state_q, state_d;
    logic                 send_bank_q, send_bank_d;
    logic                 mode_q, mode_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    logic [KW-1:0]        k_q, k_d;
    logic [PerW-1:0]      per_q, per_d;
    logic [BitPosW-1:0]   bit_pos_q, bit_pos_d;
    logic                 done_q, done_d;

    logic                 in_ready;
    logic                 accept;
    logic                 end_hold, end_period, end_sym, end_pkt;
    logic [TotalBits-1:0] bits_sh;
    logic                 bit_first, bit_second;
    logic [KW-1:0]        offset;
    logic [KW-1:0]        tab_idx;

    assign in_ready = ~full_q[fill_bank_q];
    assign accept   = bus.in_valid & in_ready;

    assign end_hold   = (hold_q == HoldLast);
    assign end_period = end_hold & (k_q == KLast);
    assign end_sym    = end_period & (per_q == PerLast);
    assign end_pkt    = end_sym & (bit_pos_q == (mode_q ? LastQpsk : LastBpsk));

    // Shifting the packet left by the bit position keeps the current symbol at the MSBs.
    assign bits_sh    = bank_q[send_bank_q] << bit_pos_q;
    assign bit_first  = bits_sh[TotalBits-1];
    assign bit_second = bits_sh[TotalBits-2];

    always_comb begin
        offset = '0;
        if (!mode_q) begin
            offset = bit_first ? OffHalf : '0;
        end else begin
            unique case ({bit_first, bit_second})
                2'b00:   offset = '0;
                2'b01:   offset = OffQuarter;
                2'b11:   offset = OffHalf;
                default: offset = Off3Q;
            endcase
        end
    end

    assign tab_idx = k_q + offset;

    always_comb begin
        full_d      = full_q;
        fill_bank_d = fill_bank_q;
        fill_ptr_d  = fill_ptr_q;
        state_d     = state_q;
        send_bank_d = send_bank_q;
        mode_d      = mode_q;
        hold_d      = hold_q;
        k_d         = k_q;
        per_d       = per_q;
        bit_pos_d   = bit_pos_q;
        done_d      = 1'b0;

        if (accept) begin
            if (fill_ptr_q == PtrLast) begin
                fill_ptr_d            = '0;
                full_d[fill_bank_q]   = 1'b1;
            end else begin
                fill_ptr_d = fill_ptr_q + PtrW'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (|full_q) begin
                    state_d     = StLoad;
                    send_bank_d = ~full_q[0];
                end
            end
            StLoad: begin
                mode_d    = bus.mode;
                hold_d    = '0;
                k_d       = '0;
                per_d     = '0;
                bit_pos_d = '0;
                state_d   = StSend;
            end
            StSend: begin
                hold_d = end_hold ? '0 : hold_q + HoldW'(1);
                if (end_hold) begin
                    k_d = k_q + KW'(1);
                end
                if (end_period) begin
                    per_d = (per_q == PerLast) ? '0 : per_q + PerW'(1);
                end
                if (end_sym) begin
                    bit_pos_d = bit_pos_q + (mode_q ? BitPosW'(2) : BitPosW'(1));
                end
                if (end_pkt) begin
                    done_d              = 1'b1;
                    full_d[send_bank_q] = 1'b0;
                    // A bank completed this same clock is picked up without an idle gap.
                    if (full_d[~send_bank_q]) begin
                        state_d     = StLoad;
                        send_bank_d = ~send_bank_q;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Fill stays parked on a full bank until the other one is released.
        if (full_d[fill_bank_q] && !full_d[~fill_bank_q]) begin
            fill_bank_d = ~fill_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            fill_bank_q <= 1'b0;
            fill_ptr_q  <= '0;
            state_q     <= StIdle;
            send_bank_q <= 1'b0;
            mode_q      <= 1'b0;
            hold_q      <= '0;
            k_q         <= '0;
            per_q       <= '0;
            bit_pos_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            full_q      <= full_d;
            fill_bank_q <= fill_bank_d;
            fill_ptr_q  <= fill_ptr_d;
            state_q     <= state_d;
            send_bank_q <= send_bank_d;
            mode_q      <= mode_d;
            hold_q      <= hold_d;
            k_q         <= k_d;
            per_q       <= per_d;
            bit_pos_q   <= bit_pos_d;
            done_q      <= done_d;
        end
    end

    // Bytes shift in from the LSB end so byte 0 ends up at the MSBs.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_q[fill_bank_q] <= TotalBits'({bank_q[fill_bank_q], bus.in_data});
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.tx_sample       = (state_q == StSend) ? sin_tab[tab_idx] : '0;
    assign bus.tx_sample_valid = (state_q == StSend) && (hold_q == '0);
    assign bus.tx_active       = (state_q != StIdle);
    assign bus.packet_done     = done_q;
endmodule

// File: tb/tb_psk_frame_modulator.sv
// Directed bench for psk_frame_modulator with N=8, hold=2, 1 period/symbol, 2-byte packets.
module tb_psk_frame_modulator;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    psk_frame_modulator_if #(.DATA_WIDTH(8)) bus ();

    psk_frame_modulator #(
        .DATA_WIDTH     (8),
        .SINE_RESOLUTION(8),
        .WAVELENGTH     (2),
        .SYMBOL_PERIODS (1),
        .PACKET_BYTES   (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int sin_ref [8] = '{0, 90, 127, 90, 0, -90, -127, -90};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;

    int               samp_q [$];
    int               strb_cyc [$];
    int               strb_n      = 0;
    int               done_cnt    = 0;
    int               hold_err    = 0;
    int               active_drop = 0;
    int               watch_until = 0;
    logic             prev_valid  = 1'b0;
    logic signed [7:0] prev_sample = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.tx_sample_valid) begin
            samp_q.push_back(int'(bus.tx_sample));
            strb_cyc.push_back(cyc);
            strb_n <= strb_n + 1;
        end
        if (prev_valid && (bus.tx_sample_valid || bus.tx_sample != prev_sample)) begin
            hold_err <= hold_err + 1;
        end
        prev_valid  <= bus.tx_sample_valid;
        prev_sample <= bus.tx_sample;
        if (bus.packet_done) done_cnt <= done_cnt + 1;
        if (!bus.tx_active && !bus.packet_done && done_cnt < watch_until) begin
            active_drop <= active_drop + 1;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int samp_at(input int i);
        return (i < samp_q.size()) ? samp_q[i] : 9999;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < strb_cyc.size()) ? strb_cyc[i] : -1;
    endfunction

    function automatic int exp_sample(input logic [7:0] b0, input logic [7:0] b1,
                                      input bit qpsk, input int i);
        logic [15:0] bits;
        int          sym;
        int          off;
        bits = {b0, b1};
        sym  = i / 8;
        if (!qpsk) begin
            off = bits[15-sym] ? 4 : 0;
        end else begin
            case ({bits[15-2*sym], bits[14-2*sym]})
                2'b00:   off = 0;
                2'b01:   off = 2;
                2'b11:   off = 4;
                default: off = 6;
            endcase
        end
        return sin_ref[(i % 8 + off) % 8];
    endfunction

    task automatic check_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                                input bit qpsk, input int base);
        int n;
        n = qpsk ? 64 : 128;
        for (int i = 0; i < n; i++) begin
            check_eq(tag, samp_at(base + i), exp_sample(b0, b1, qpsk, i));
        end
    endtask

    // Called on a negedge; leaves in_valid high so consecutive calls stream back-to-back.
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard        = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("in_ready_wait", int'(bus.in_ready), 1);
        last_acc = cyc;
        @(negedge clk);
    endtask

    task automatic gap_cycles(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, done_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int d0;
        int s0;
        int ad0;
        int acc0;
        int guard;
        int sym0 [8] = '{0, -90, -127, -90, 0, 90, 127, 90};

        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.mode     = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_in_ready", int'(bus.in_ready), 1);
        check_eq("rst_tx_sample", int'(bus.tx_sample), 0);
        check_eq("rst_tx_valid", int'(bus.tx_sample_valid), 0);
        check_eq("rst_tx_active", int'(bus.tx_active), 0);
        check_eq("rst_packet_done", int'(bus.packet_done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // BPSK 0x80,0x00: symbol 0 shifted by half a period, the rest unshifted.
        samp_q.delete();
        strb_cyc.delete();
        d0 = done_cnt;
        send_byte(8'h80);
        send_byte(8'h00);
        bus.in_valid = 1'b0;
        wait_done("t1_done", d0 + 1, 400);
        repeat (5) @(negedge clk);
        check_eq("t1_done_once", done_cnt, d0 + 1);
        check_eq("t1_strobes", samp_q.size(), 128);
        // Accept edge follows the negedge that saw in_ready; strobe at edge t+2 shows at +3.
        check_eq("t1_latency", cyc_at(0) - last_acc, 3);
        for (int i = 0; i < 8; i++) check_eq("t1_sym0", samp_at(i), sym0[i]);
        for (int s = 1; s < 16; s++) begin
            check_eq("t1_symn_s0", samp_at(s * 8), 0);
            check_eq("t1_symn_s1", samp_at(s * 8 + 1), 90);
            check_eq("t1_symn_s2", samp_at(s * 8 + 2), 127);
        end
        check_eq("t1_hold_spacing", cyc_at(1) - cyc_at(0), 2);
        check_packet("t1_model", 8'h80, 8'h00, 1'b0, 0);

        // QPSK 0x1B,0x1B: dibits 00,01,10,11 -> offsets 0,2,6,4.
        bus.mode = 1'b1;
        samp_q.delete();
        strb_cyc.delete();
        d0 = done_cnt;
        send_byte(8'h1B);
        send_byte(8'h1B);
        bus.in_valid = 1'b0;
        wait_done("t2_done", d0 + 1, 400);
        repeat (3) @(negedge clk);
        check_eq("t2_strobes", samp_q.size(), 64);
        check_eq("t2_sym0", samp_at(0), 0);
        check_eq("t2_sym1", samp_at(8), 127);
        check_eq("t2_sym2", samp_at(16), -127);
        check_eq("t2_sym3", samp_at(24), 0);
        check_packet("t2_model", 8'h1B, 8'h1B, 1'b1, 0);

        // Two packets streamed back-to-back.
        bus.mode = 1'b0;
        samp_q.delete();
        strb_cyc.delete();
        d0  = done_cnt;
        ad0 = active_drop;
        send_byte(8'hA1);
        acc0 = last_acc;
        send_byte(8'hB2);
        send_byte(8'hC3);
        send_byte(8'hD4);
        check_eq("t3_back_to_back", last_acc - acc0, 3);
        check_eq("t3_in_ready_low", int'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
        watch_until  = d0 + 2;
        wait_done("t3_done", d0 + 2, 900);
        repeat (3) @(negedge clk);
        check_eq("t3_strobes", samp_q.size(), 256);
        // Only the single LOAD clock separates the last hold from the next packet.
        check_eq("t3_gap", cyc_at(128) - cyc_at(127), 3);
        check_eq("t3_active_drop", active_drop - ad0, 0);
        check_eq("t3_in_ready_back", int'(bus.in_ready), 1);
        check_packet("t3_pkt0", 8'hA1, 8'hB2, 1'b0, 0);
        check_packet("t3_pkt1", 8'hC3, 8'hD4, 1'b0, 128);

        // Reset mid-packet with a partially filled second bank.
        samp_q.delete();
        strb_cyc.delete();
        d0 = done_cnt;
        s0 = strb_n;
        send_byte(8'hFF);
        send_byte(8'h0F);
        send_byte(8'h55);
        bus.in_valid = 1'b0;
        guard = 0;
        while (strb_n < s0 + 20 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check_eq("t4_reach_strobe20", strb_n - s0, 20);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t4_rst_sample", int'(bus.tx_sample), 0);
        check_eq("t4_rst_valid", int'(bus.tx_sample_valid), 0);
        check_eq("t4_rst_active", int'(bus.tx_active), 0);
        check_eq("t4_rst_done", int'(bus.packet_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t4_in_ready", int'(bus.in_ready), 1);
        repeat (20) @(negedge clk);
        check_eq("t4_no_done", done_cnt, d0);
        samp_q.delete();
        strb_cyc.delete();
        send_byte(8'h80);
        send_byte(8'h00);
        bus.in_valid = 1'b0;
        wait_done("t4_done", d0 + 1, 400);
        repeat (3) @(negedge clk);
        check_eq("t4_strobes", samp_q.size(), 128);
        check_packet("t4_model", 8'h80, 8'h00, 1'b0, 0);

        // Mode toggled mid-packet; bytes arrive with random gaps.
        bus.mode = 1'b1;
        samp_q.delete();
        strb_cyc.delete();
        d0 = done_cnt;
        s0 = strb_n;
        gap_cycles($urandom_range(0, 3));
        send_byte(8'h4E);
        gap_cycles($urandom_range(0, 3));
        send_byte(8'hD2);
        bus.in_valid = 1'b0;
        guard = 0;
        while (strb_n <= s0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("t5_started", int'(strb_n > s0), 1);
        fork
            begin
                gap_cycles($urandom_range(0, 3));
                send_byte(8'h39);
                gap_cycles($urandom_range(0, 3));
                send_byte(8'hC7);
                bus.in_valid = 1'b0;
            end
            begin
                repeat (30) begin
                    @(negedge clk);
                    bus.mode = ~bus.mode;
                end
                bus.mode = 1'b0;
            end
        join
        wait_done("t5_done", d0 + 2, 900);
        repeat (3) @(negedge clk);
        check_eq("t5_strobes", samp_q.size(), 192);
        check_packet("t5_qpsk", 8'h4E, 8'hD2, 1'b1, 0);
        check_packet("t5_bpsk", 8'h39, 8'hC7, 1'b0, 64);

        check_eq("hold_violations", hold_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
